interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Sequences interrupt entry and exit for the pipelined CPU.
- Arbitrates level-sensitive device requests and holds the system registers PCS, IHA, IRA and IDN.
- Drives intaSig and intaAddr toward the decode/PC-select logic, which forces pcSel=2'b11 while intaSig is high.
- Consumes isReti, isRSR and isWSR from the instruction controller and returns sysDataOut1 for RSR.

Parameters:
NUM_DEV, 4, number of external interrupt request lines (1..8)
DATA_WIDTH, 32, width of system registers and data ports
IHA_RESET, 32'h00000040, reset value of the interrupt handler address register

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
intReq  input  NUM_DEV  level-sensitive device requests; bit 0 is highest priority
pipeReady  input  1  high when the pipeline can be redirected this cycle (no stall, no branch in flight)
pcResume  input  DATA_WIDTH  address of the oldest unretired instruction, saved to IRA on entry
isReti  input  1  RETI decoded this cycle
isRSR  input  1  RSR decoded this cycle
isWSR  input  1  WSR decoded this cycle
sysRegAddr  input  4  system register index for RSR/WSR
sysDataIn  input  DATA_WIDTH  write data for WSR
sysDataOut1  output  DATA_WIDTH  combinational read data for RSR
intaSig  output  1  one-cycle interrupt-acknowledge pulse to the controller
intaAddr  output  DATA_WIDTH  PC target when pcSel=2'b11
intAck  output  NUM_DEV  one-hot acknowledge to the granted device, same cycle as intaSig
inHandler  output  1  high from the intaSig cycle until the cycle after the accepted RETI

Behaviour:
- System register map (sysRegAddr):
  - 0 PCS: bit0 IE, bit1 OIE, other bits read 0.
  - 1 IHA: read/write.
  - 2 IRA: read/write.
  - 3 IDN: read-only; writes are ignored.
  - Any other index reads 0; writes to it are ignored.
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, PCS=0, IHA=IHA_RESET, IRA=0, IDN=0.
  - intaSig=0, intAck=0, inHandler=0.
  - Reset overrides every event, including an in-progress handler.
- FSM states: IDLE, ACK, HANDLER.
- IDLE -> ACK when IE=1, |intReq, pipeReady=1, and isWSR=0 and isReti=0 this cycle. At that edge:
  - IDN <= index of the lowest set intReq bit (zero-extended).
  - IRA <= pcResume.
  - OIE <= IE, IE <= 0.
- ACK lasts exactly one cycle:
  - intaSig=1, intAck[IDN]=1, intaAddr=IHA.
  - Always moves to HANDLER on the next edge.
- HANDLER:
  - intReq is ignored regardless of IE; there is no nesting.
  - isReti -> IDLE at the next edge and IE <= OIE; inHandler drops on that edge.
- intaAddr: equals IHA in ACK, otherwise IRA. RETI therefore redirects to IRA in the same cycle it is decoded.
- isReti while in IDLE: IE <= OIE and state stays IDLE. This is legal; software may build its own return.
- RSR: sysDataOut1 = register[sysRegAddr], read combinationally.
  - WSR writes at the clock edge, so a same-cycle RSR returns the pre-write value.
  - The value returned for IRA/IDN in ACK is the value already latched for this interrupt.
- WSR to PCS in the same cycle as a qualifying request: the request is not taken. The new IE applies from the next cycle.
- WSR and isReti asserted together: WSR writes first, then RETI restores IE from the old OIE (RETI wins for IE).
- A request deasserting during ACK: the acknowledge still completes with the latched IDN.
- Outputs intaSig, intAck and inHandler are registered or decoded from state only; no combinational path from intReq.

Optional Feature:
- Macro: INTC_TIMER_EN.
- With the macro defined:
  - Adds an internal timer request at priority index NUM_DEV, lowest priority.
  - Adds system register 4 TLIM (read/write, reset 0) and 5 TCNT (read/write, reset 0).
  - When TLIM!=0, TCNT increments each cycle. When TCNT==TLIM-1 it wraps to 0 and sets a sticky pending bit.
  - The pending bit clears in the ACK cycle that grants the timer (IDN=NUM_DEV).
  - intAck is unaffected by a timer grant.
  - Writing TLIM also clears TCNT.
- Without the macro: indices 4 and 5 read 0 and writes are ignored; no timer logic is present.

Test Plan:
- Reset, then RSR of indices 0..3 -> returns 0, IHA_RESET, 0, 0; intaSig=0.
- WSR PCS=1; intReq=4'b0110, pipeReady=1, pcResume=0x100:
  - Next cycle intaSig=1, intAck=4'b0010, intaAddr=IHA.
  - Afterwards IDN=1, IRA=0x100, PCS=2'b10.
- In HANDLER, raise intReq=4'b0001 -> no intaSig. RETI -> intaAddr=0x100 that cycle, then IE=1, state IDLE, and the pending request is taken the following cycle.
- IE=1 with a request pending and pipeReady=0 for 3 cycles -> no ACK. pipeReady=1 -> ACK on the next cycle.
- Same-cycle WSR PCS=0 with a request pending -> no ACK, IE=0 afterwards. Assert reset_n=0 during HANDLER -> IDLE, all registers at reset values.
- INTC_TIMER_EN defined, TLIM=5, IE=1, intReq=0 -> timer ACK 5 cycles after the TLIM write, IDN=NUM_DEV, intAck=0.

Source files
------------

// File: rtl/interrupt_controller.sv
// Interrupt entry/exit sequencer and system register file (PCS, IHA, IRA, IDN).
// Optional internal timer interrupt is enabled by defining INTC_TIMER_EN.
module interrupt_controller #(
  parameter int unsigned           NUM_DEV    = 4,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] IHA_RESET  = DATA_WIDTH'(32'h00000040)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_DEV-1:0]    intReq,
  input  logic                  pipeReady,
  input  logic [DATA_WIDTH-1:0] pcResume,
  input  logic                  isReti,
  input  logic                  isRSR,
  input  logic                  isWSR,
  input  logic [3:0]            sysRegAddr,
  input  logic [DATA_WIDTH-1:0] sysDataIn,
  output logic [DATA_WIDTH-1:0] sysDataOut1,
  output logic                  intaSig,
  output logic [DATA_WIDTH-1:0] intaAddr,
  output logic [NUM_DEV-1:0]    intAck,
  output logic                  inHandler
);

  localparam int unsigned IDW = $clog2(NUM_DEV + 1);
`ifdef INTC_TIMER_EN
  localparam int unsigned NREQ = NUM_DEV + 1;
`else
  localparam int unsigned NREQ = NUM_DEV;
`endif

  typedef enum logic [1:0] {IDLE, ACK, HANDLER} state_t;

  state_t                  state, next_state;
  logic                    ie, oie;
  logic [DATA_WIDTH-1:0]   iha, ira;
  logic [IDW-1:0]          idn;
  logic [NREQ-1:0]         req;
  logic [IDW-1:0]          grant;
  logic                    take;

`ifdef INTC_TIMER_EN
  logic [DATA_WIDTH-1:0]   tlim, tcnt;
  logic                    tmr_pend;
  logic                    tmr_hit;

  // The wrap cycle itself already requests, so the grant lands one cycle
  // earlier than waiting for the sticky bit to be visible.
  assign tmr_hit = (tlim != '0) && (tcnt == tlim - DATA_WIDTH'(1));
  assign req     = {tmr_pend | tmr_hit, intReq};

  // Timer counter, limit and sticky pending bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tlim     <= '0;
      tcnt     <= '0;
      tmr_pend <= 1'b0;
    end else begin
      if (state == ACK && idn == IDW'(NUM_DEV))
        tmr_pend <= 1'b0;
      if (tmr_hit) begin
        tcnt     <= '0;
        tmr_pend <= 1'b1;
      end else if (tlim != '0) begin
        tcnt <= tcnt + DATA_WIDTH'(1);
      end
      if (isWSR && sysRegAddr == 4'd4) begin
        tlim <= sysDataIn;
        tcnt <= '0;
      end
      if (isWSR && sysRegAddr == 4'd5)
        tcnt <= sysDataIn;
    end
  end
`else
  assign req = intReq;
`endif

  // Lowest-index request wins
  always_comb begin
    grant = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (req[i-1]) grant = IDW'(i - 1);
    end
  end

  assign take = (state == IDLE) && ie && (|req) && pipeReady && !isWSR && !isReti;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    next_state = state;
    intaSig    = 1'b0;
    inHandler  = 1'b0;
    intaAddr   = ira;
    intAck     = '0;
    case (state)
      IDLE: begin
        if (take) next_state = ACK;
      end
      ACK: begin
        next_state = HANDLER;
        intaSig    = 1'b1;
        inHandler  = 1'b1;
        intaAddr   = iha;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
          if (idn == IDW'(i)) intAck[i] = 1'b1;
        end
      end
      HANDLER: begin
        inHandler = 1'b1;
        if (isReti) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // System registers; WSR applies first, then entry/RETI effects override
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ie  <= 1'b0;
      oie <= 1'b0;
      iha <= IHA_RESET;
      ira <= '0;
      idn <= '0;
    end else begin
      if (isWSR) begin
        case (sysRegAddr)
          4'd0: begin
            ie  <= sysDataIn[0];
            oie <= sysDataIn[1];
          end
          4'd1:    iha <= sysDataIn;
          4'd2:    ira <= sysDataIn;
          default: ;
        endcase
      end
      if (take) begin
        idn <= grant;
        ira <= pcResume;
        oie <= ie;
        ie  <= 1'b0;
      end
      if (isReti && state != ACK)
        ie <= oie;
    end
  end

  // Combinational RSR read port
  always_comb begin
    sysDataOut1 = '0;
    if (isRSR) begin
      case (sysRegAddr)
        4'd0: begin
          sysDataOut1[0] = ie;
          sysDataOut1[1] = oie;
        end
        4'd1: sysDataOut1 = iha;
        4'd2: sysDataOut1 = ira;
        4'd3: sysDataOut1[IDW-1:0] = idn;
`ifdef INTC_TIMER_EN
        4'd4: sysDataOut1 = tlim;
        4'd5: sysDataOut1 = tcnt;
`endif
        default: sysDataOut1 = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

  logic        clk;
  logic        reset_n;
  logic [3:0]  intReq;
  logic        pipeReady;
  logic [31:0] pcResume;
  logic        isReti, isRSR, isWSR;
  logic [3:0]  sysRegAddr;
  logic [31:0] sysDataIn;
  logic [31:0] sysDataOut1;
  logic        intaSig;
  logic [31:0] intaAddr;
  logic [3:0]  intAck;
  logic        inHandler;

  int errors = 0;
  int checks = 0;

  interrupt_controller #(
    .NUM_DEV   (4),
    .DATA_WIDTH(32),
    .IHA_RESET (32'h00000040)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .intReq     (intReq),
    .pipeReady  (pipeReady),
    .pcResume   (pcResume),
    .isReti     (isReti),
    .isRSR      (isRSR),
    .isWSR      (isWSR),
    .sysRegAddr (sysRegAddr),
    .sysDataIn  (sysDataIn),
    .sysDataOut1(sysDataOut1),
    .intaSig    (intaSig),
    .intaAddr   (intaAddr),
    .intAck     (intAck),
    .inHandler  (inHandler)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    sysRegAddr = a;
    #1;
    chk(tag, sysDataOut1, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    isWSR      = 1'b1;
    sysRegAddr = a;
    sysDataIn  = d;
    tick();
    isWSR      = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; intReq = '0; pipeReady = 1'b0; pcResume = '0;
    isReti = 1'b0; isRSR = 1'b1; isWSR = 1'b0; sysRegAddr = '0; sysDataIn = '0;
    tick(); tick();
    reset_n = 1'b1;

    // Reset values
    rd("rst_pcs", 4'd0, 32'h0);
    rd("rst_iha", 4'd1, 32'h40);
    rd("rst_ira", 4'd2, 32'h0);
    rd("rst_idn", 4'd3, 32'h0);
    chk("rst_inta", 32'(intaSig), 32'h0);
    chk("rst_inh", 32'(inHandler), 32'h0);
    chk("rst_ack", 32'(intAck), 32'h0);
    rd("unmapped7", 4'd7, 32'h0);
    wr(4'd3, 32'h7);
    rd("idn_ro", 4'd3, 32'h0);

    // First interrupt: two requests, bit 1 wins
    intReq = 4'b0110; pipeReady = 1'b1; pcResume = 32'h100;
    wr(4'd0, 32'h1);
    chk("wsr_no_take", 32'(intaSig), 32'h0);
    tick();
    chk("ack1_inta", 32'(intaSig), 32'h1);
    chk("ack1_intack", 32'(intAck), 32'h2);
    chk("ack1_addr", intaAddr, 32'h40);
    chk("ack1_inh", 32'(inHandler), 32'h1);
    rd("ack1_idn", 4'd3, 32'h1);
    rd("ack1_ira", 4'd2, 32'h100);
    rd("ack1_pcs", 4'd0, 32'h2);

    // Handler: no nesting
    intReq = 4'b0001;
    tick();
    chk("hnd_inta", 32'(intaSig), 32'h0);
    chk("hnd_intack", 32'(intAck), 32'h0);
    chk("hnd_inh", 32'(inHandler), 32'h1);
    tick();
    chk("hnd_nonest", 32'(intaSig), 32'h0);

    // RETI redirects to IRA, then pending request taken
    isReti = 1'b1; pcResume = 32'h200;
    #1;
    chk("reti_addr", intaAddr, 32'h100);
    tick();
    isReti = 1'b0;
    rd("reti_pcs", 4'd0, 32'h3);
    chk("reti_inh", 32'(inHandler), 32'h0);
    chk("reti_inta", 32'(intaSig), 32'h0);
    tick();
    chk("ack2_inta", 32'(intaSig), 32'h1);
    chk("ack2_intack", 32'(intAck), 32'h1);
    rd("ack2_idn", 4'd3, 32'h0);
    rd("ack2_ira", 4'd2, 32'h200);
    rd("ack2_pcs", 4'd0, 32'h2);
    tick();

    // Stalled pipeline holds off entry
    isReti = 1'b1; pipeReady = 1'b0; intReq = 4'b0100;
    tick();
    isReti = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_noack", 32'(intaSig), 32'h0);
    end
    pipeReady = 1'b1;
    tick();
    chk("ack3_inta", 32'(intaSig), 32'h1);
    chk("ack3_intack", 32'(intAck), 32'h4);
    rd("ack3_idn", 4'd3, 32'h2);
    tick();

    // WSR PCS=0 in the same cycle as a qualifying request
    isReti = 1'b1; intReq = 4'b1000;
    tick();
    isReti = 1'b0;
    wr(4'd0, 32'h0);
    chk("wsr_block", 32'(intaSig), 32'h0);
    rd("wsr_pcs", 4'd0, 32'h0);
    tick();
    chk("ie0_noack", 32'(intaSig), 32'h0);

    // New IHA, request dropping during ACK, reset during HANDLER
    wr(4'd1, 32'h80);
    wr(4'd0, 32'h1);
    tick();
    chk("ack4_addr", intaAddr, 32'h80);
    chk("ack4_intack", 32'(intAck), 32'h8);
    intReq = 4'b0000;
    tick();
    rd("ack4_idn", 4'd3, 32'h3);
    chk("ack4_inh", 32'(inHandler), 32'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst2_inh", 32'(inHandler), 32'h0);
    rd("rst2_pcs", 4'd0, 32'h0);
    rd("rst2_iha", 4'd1, 32'h40);
    rd("rst2_ira", 4'd2, 32'h0);
    rd("rst2_idn", 4'd3, 32'h0);

    // WSR and RETI together: IE comes from the old OIE
    wr(4'd0, 32'h2);
    isReti = 1'b1;
    wr(4'd0, 32'h0);
    isReti = 1'b0;
    rd("wsr_reti_pcs", 4'd0, 32'h1);
    chk("wsr_reti_inta", 32'(intaSig), 32'h0);

`ifdef INTC_TIMER_EN
    // Timer request five cycles after TLIM write
    wr(4'd4, 32'h5);
    rd("tlim_rd", 4'd4, 32'h5);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tmr_wait", 32'(intaSig), 32'h0);
    end
    tick();
    chk("tmr_inta", 32'(intaSig), 32'h1);
    chk("tmr_intack", 32'(intAck), 32'h0);
    rd("tmr_idn", 4'd3, 32'h4);
`else
    rd("idx4_zero", 4'd4, 32'h0);
    wr(4'd5, 32'h9);
    rd("idx5_zero", 4'd5, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
